// File: rtl/sw_pkg.sv
// Shared Smith-Waterman package, used by the target feeder and the PE array.
// Contents: nucleotide encodings, default score width, biased-zero helper,
// and the one-hot feeder state encoding.
package sw_pkg;
  localparam logic [1:0] _A = 2'b00;
  localparam logic [1:0] _G = 2'b01;
  localparam logic [1:0] _T = 2'b10;
  localparam logic [1:0] _C = 2'b11;

  localparam int SCORE_WIDTH_DEF = 12;

  // Scores are carried with a bias of half the range so that "zero" sits
  // mid-scale and negative intermediate values need no sign handling.
  function automatic int zero_bias(input int w);
    return 1 << (w - 1);
  endfunction

  typedef enum logic [3:0] {
    ST_LOAD     = 4'b0001,
    ST_PRIME    = 4'b0010,
    ST_STREAM   = 4'b0100,
    ST_WAIT_RES = 4'b1000
  } feed_state_t;
endpackage

// File: rtl/sw_target_feeder_if.sv
// Target base stream (valid/ready) into the feeder.
//   s_valid : beat valid          s_ready : feeder can accept
//   s_base  : 2-bit base          s_last  : final base of sequence
// master = upstream source, slave = feeder.
interface sw_target_feeder_if;
  logic       s_valid;
  logic       s_ready;
  logic [1:0] s_base;
  logic       s_last;

  modport master (output s_valid, s_base, s_last, input s_ready);
  modport slave  (input s_valid, s_base, s_last, output s_ready);
endinterface

// File: rtl/sw_target_buf.sv
// Target sequence buffer: simple dual-port RAM, 2**ADDR_W x 2 bits.
// One write port, one synchronous read port (data one cycle after address).
// No reset; contents are undefined until written.
//   clk, we, waddr, wdata : write port
//   raddr, rdata          : read port
module sw_target_buf #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [1:0]        wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [1:0]        rdata
);
  logic [1:0] mem [1<<ADDR_W];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end
endmodule

// File: rtl/sw_target_feeder.sv
// Smith-Waterman target feeder. Buffers a whole target sequence from the
// input stream, then drives the first PE with a gap-free enable burst of one
// base per cycle and biased-zero boundary scores, then waits for the last PE's
// result before accepting the next sequence.
//   clk, rst        : clock, async active-high reset
//   s               : target base stream (slave modport)
//   pe_en, pe_data  : enable / base to first PE
//   pe_M/I/High     : boundary scores, constant ZERO
//   res_vld         : result valid from last PE
//   busy            : not in LOAD
//   seq_len         : stored length of current sequence
//   ovf             : sticky, sequence was truncated to MAX_LEN
module sw_target_feeder
  import sw_pkg::*;
#(
  parameter int SCORE_WIDTH = SCORE_WIDTH_DEF,
  parameter int LEN_WIDTH   = 10
) (
  input  logic                   clk,
  input  logic                   rst,
  sw_target_feeder_if.slave      s,
  output logic                   pe_en,
  output logic [1:0]             pe_data,
  output logic [SCORE_WIDTH-1:0] pe_M,
  output logic [SCORE_WIDTH-1:0] pe_I,
  output logic [SCORE_WIDTH-1:0] pe_High,
  input  logic                   res_vld,
  output logic                   busy,
  output logic [LEN_WIDTH:0]     seq_len,
  output logic                   ovf
);
  localparam logic [LEN_WIDTH:0]     MAX_CNT = (LEN_WIDTH+1)'(1 << LEN_WIDTH);
  localparam logic [SCORE_WIDTH-1:0] ZERO    = SCORE_WIDTH'(zero_bias(SCORE_WIDTH));

  feed_state_t        state_q, state_d;
  logic [LEN_WIDTH:0] wr_cnt, rd_cnt;
  logic               beat, has_room, rd_last;
  logic [1:0]         rd_data;

  assign beat     = s.s_valid & s.s_ready;
  assign has_room = wr_cnt < MAX_CNT;
  // rd_cnt runs one ahead of the base being presented, so the last base is
  // on the bus when rd_cnt reaches seq_len.
  assign rd_last  = rd_cnt == seq_len;

  assign s.s_ready = state_q == ST_LOAD;
  assign busy      = state_q != ST_LOAD;
  assign pe_M      = ZERO;
  assign pe_I      = ZERO;
  assign pe_High   = ZERO;
  // The RAM output register supplies the base; it has no reset, so it is
  // masked by the registered enable to keep pe_data at 00 outside a burst.
  assign pe_data   = pe_en ? rd_data : 2'b00;

  sw_target_buf #(.ADDR_W(LEN_WIDTH)) u_buf (
    .clk   (clk),
    .we    (beat & has_room),
    .waddr (wr_cnt[LEN_WIDTH-1:0]),
    .wdata (s.s_base),
    .raddr (rd_cnt[LEN_WIDTH-1:0]),
    .rdata (rd_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_LOAD;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_LOAD:     if (beat && s.s_last) state_d = ST_PRIME;
      ST_PRIME:    state_d = ST_STREAM;
      ST_STREAM:   if (rd_last) state_d = ST_WAIT_RES;
      ST_WAIT_RES: if (res_vld) state_d = ST_LOAD;
      default:     state_d = ST_LOAD;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_cnt  <= '0;
      rd_cnt  <= '0;
      seq_len <= '0;
      ovf     <= 1'b0;
      pe_en   <= 1'b0;
    end else begin
      pe_en <= state_d == ST_STREAM;
      case (state_q)
        ST_LOAD: if (beat) begin
          if (has_room) wr_cnt <= wr_cnt + 1'b1;
          else          ovf    <= 1'b1;
          if (s.s_last) seq_len <= has_room ? wr_cnt + 1'b1 : wr_cnt;
        end
        // rd_cnt is 0 here, so buf[0] is being read this cycle.
        ST_PRIME:  rd_cnt <= (LEN_WIDTH+1)'(1);
        ST_STREAM: if (!rd_last) rd_cnt <= rd_cnt + 1'b1;
        ST_WAIT_RES: if (res_vld) begin
          wr_cnt <= '0;
          rd_cnt <= '0;
          ovf    <= 1'b0;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_sw_target_feeder.sv
module tb_sw_target_feeder;
  logic        clk = 1'b0;
  logic        rst;
  logic        res_vld;
  logic        pe_en, busy, ovf;
  logic [1:0]  pe_data;
  logic [11:0] pe_M, pe_I, pe_High;
  logic [10:0] seq_len;
  int          checks = 0;
  int          failures = 0;

  sw_target_feeder_if sif ();

  sw_target_feeder #(.SCORE_WIDTH(12), .LEN_WIDTH(10)) dut (
    .clk(clk), .rst(rst), .s(sif),
    .pe_en(pe_en), .pe_data(pe_data), .pe_M(pe_M), .pe_I(pe_I), .pe_High(pe_High),
    .res_vld(res_vld), .busy(busy), .seq_len(seq_len), .ovf(ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          len;
    logic [15:0] bases;    // base i at [2i+1:2i]
    bit          stall;
    logic [15:0] exp_data; // expected pe_data for burst cycle k at [2k+1:2k]
    int          exp_len;
  } vec_t;

  vec_t vecs[4];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
    end
  endtask

  task automatic send_beat(input logic [1:0] b, input logic last, input logic rv);
    sif.s_valid = 1'b1;
    sif.s_base  = b;
    sif.s_last  = last;
    res_vld     = rv;
    @(posedge clk); #1;
    sif.s_valid = 1'b0;
    sif.s_last  = 1'b0;
    res_vld     = 1'b0;
  endtask

  // Called right after the s_last transfer edge; checks PRIME, burst, hold
  // in WAIT_RES and release by res_vld.
  task automatic check_burst(input int len, input logic [15:0] exp, input bit long_mode,
                             input int exp_len, input logic exp_ovf);
    int bad = 0;
    logic [1:0] e;
    @(negedge clk);
    chk("prime_en", pe_en, 0);
    chk("prime_ready", sif.s_ready, 0);
    chk("prime_busy", busy, 1);
    for (int k = 0; k < len; k++) begin
      @(negedge clk);
      res_vld = 1'b0;
      e = long_mode ? 2'(k) : exp[2*k +: 2];
      if (long_mode) begin
        if (pe_en !== 1'b1 || pe_data !== e) bad++;
      end else begin
        chk($sformatf("burst_en_%0d", k), pe_en, 1);
        chk($sformatf("burst_data_%0d", k), pe_data, e);
        if (k == 1 && len >= 3) res_vld = 1'b1; // must be ignored in STREAM
      end
    end
    res_vld = 1'b0;
    if (long_mode) chk("long_burst_bad", bad, 0);
    @(negedge clk);
    chk("tail_en", pe_en, 0);
    chk("tail_data", pe_data, 0);
    chk("seq_len", seq_len, exp_len);
    chk("ovf", ovf, exp_ovf);
    chk("pe_I", pe_I, 12'h800);
    repeat (2) @(negedge clk);
    chk("wait_en", pe_en, 0);
    chk("wait_ready", sif.s_ready, 0);
    chk("wait_busy", busy, 1);
    res_vld = 1'b1;
    @(negedge clk);
    res_vld = 1'b0;
    chk("release_ready", sif.s_ready, 1);
    chk("release_busy", busy, 0);
    chk("release_ovf", ovf, 0);
    chk("release_len_hold", seq_len, exp_len);
  endtask

  task automatic run_vec(input int v);
    for (int i = 0; i < vecs[v].len; i++) begin
      if (vecs[v].stall && $urandom_range(1) == 1) begin
        @(posedge clk); #1;
      end
      send_beat(vecs[v].bases[2*i +: 2], i == vecs[v].len - 1, i == 2);
    end
    check_burst(vecs[v].len, vecs[v].exp_data, 1'b0, vecs[v].exp_len, 1'b0);
  endtask

  task automatic run_long(input int n, input logic exp_ovf);
    for (int i = 0; i < n; i++) send_beat(2'(i), i == n - 1, 1'b0);
    check_burst(1024, 16'h0, 1'b1, 1024, exp_ovf);
  endtask

  initial begin
    vecs[0] = '{4, 16'h00E4, 1'b0, 16'h00E4, 4};  // A,G,T,C
    vecs[1] = '{1, 16'h0002, 1'b0, 16'h0002, 1};  // T
    vecs[2] = '{8, 16'hC963, 1'b1, 16'hC963, 8};  // C,A,T,G,G,T,A,C with stalls
    vecs[3] = '{2, 16'h000D, 1'b0, 16'h000D, 2};  // G,C

    sif.s_valid = 1'b0;
    sif.s_base  = 2'b00;
    sif.s_last  = 1'b0;
    res_vld     = 1'b0;
    rst         = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_ready", sif.s_ready, 1);
    chk("rst_en", pe_en, 0);
    chk("rst_data", pe_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_seq_len", seq_len, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_pe_M", pe_M, 12'h800);
    chk("rst_pe_High", pe_High, 12'h800);
    rst = 1'b0;

    // res_vld in LOAD: no state change
    @(negedge clk);
    res_vld = 1'b1;
    @(negedge clk);
    res_vld = 1'b0;
    chk("load_resvld_ready", sif.s_ready, 1);
    chk("load_resvld_busy", busy, 0);

    for (int v = 0; v < 3; v++) run_vec(v);

    // reset during 3rd STREAM cycle of a 5-base sequence
    @(negedge clk);
    send_beat(2'b00, 1'b0, 1'b0);
    send_beat(2'b01, 1'b0, 1'b0);
    send_beat(2'b10, 1'b0, 1'b0);
    send_beat(2'b11, 1'b0, 1'b0);
    send_beat(2'b00, 1'b1, 1'b0);
    repeat (4) @(negedge clk);
    chk("pre_rst_en", pe_en, 1);
    chk("pre_rst_data", pe_data, 2'b10);
    #1 rst = 1'b1;
    #1;
    chk("midrst_en", pe_en, 0);
    chk("midrst_ready", sif.s_ready, 1);
    chk("midrst_busy", busy, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_vec(3);

    run_long(1024, 1'b0);
    run_long(1027, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/sw_target_feeder.md
# sw_target_feeder

Upstream stage of the Smith-Waterman systolic array. Accepts a target sequence as a valid/ready stream of 2-bit bases and stores it whole in a local buffer. Then drives the first processing element with an unbroken enable burst of exactly one base per cycle, plus biased-zero boundary scores. It then holds off the next sequence until the last processing element reports its result. A gap-free burst is required because any enable gap ends the array's calculation.

## Interface
Parameters:
- SCORE_WIDTH, 12, width of score buses; biased zero ZERO = 2**(SCORE_WIDTH-1)
- LEN_WIDTH, 10, buffer address width; MAX_LEN = 2**LEN_WIDTH bases

Ports:
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  reset, asynchronous, active-high
- s_valid  in  1  target base beat valid
- s_ready  out  1  feeder can accept a beat
- s_base  in  2  base, A=00 G=01 T=10 C=11
- s_last  in  1  final base of the sequence
- pe_en  out  1  enable to first PE
- pe_data  out  2  target base to first PE
- pe_M  out  SCORE_WIDTH  M boundary score, constant ZERO
- pe_I  out  SCORE_WIDTH  I boundary score, constant ZERO
- pe_High  out  SCORE_WIDTH  High boundary score, constant ZERO
- res_vld  in  1  vld from last PE of the array
- busy  out  1  high in any state other than LOAD
- seq_len  out  LEN_WIDTH+1  stored length of current sequence
- ovf  out  1  sticky: current sequence exceeded MAX_LEN, truncated

## Operation
- States: LOAD, PRIME, STREAM, WAIT_RES. Reset state is LOAD.
- LOAD:
  - s_ready=1.
  - A beat transfers on s_valid&s_ready.
  - If wr_cnt<MAX_LEN, the base is written to buf[wr_cnt] and wr_cnt increments.
  - Otherwise the beat is accepted and discarded, and ovf is set.
  - On a transferred beat with s_last=1: seq_len takes the final stored count, and the FSM goes to PRIME.
  - Length is always ≥1.
- PRIME:
  - s_ready=0.
  - buf[0] is read (synchronous-read RAM) and rd_cnt is set to 1.
  - Lasts one cycle, then STREAM.
- STREAM:
  - pe_en=1 and pe_data=buffer read data, one new base per cycle, no gaps, for exactly seq_len cycles.
  - The buffer is read ahead by rd_cnt.
  - On the cycle that presents the last base, the next state is WAIT_RES.
- WAIT_RES:
  - pe_en=0 and pe_data=00.
  - On res_vld=1: wr_cnt, rd_cnt and ovf are cleared and the FSM goes to LOAD.
  - seq_len holds until the next s_last.
- res_vld is ignored outside WAIT_RES.
- s_valid while s_ready=0: the beat is not taken and the upstream holds it.
- pe_M, pe_I and pe_High are constant ZERO and unaffected by reset or state.
- Counters are LEN_WIDTH+1 bits wide so that MAX_LEN is representable; no wrap-around is permitted.

## Timing
- Reset values:
  - s_ready=1, pe_en=0, pe_data=00, busy=0, seq_len=0, ovf=0.
  - wr_cnt=0, rd_cnt=0, state LOAD.
- Buffer contents are undefined after reset.
- pe_en and pe_data are registered.
- For an s_last transfer in cycle t:
  - t+1: PRIME.
  - pe_en high in cycles t+2 … t+1+seq_len.
  - pe_en low from t+2+seq_len.
- pe_en is always low for at least one cycle between sequences, guaranteed by WAIT_RES.
- res_vld in cycle r gives s_ready=1 at r+1, so the next beat can transfer at r+1.
- Reset asserted mid-STREAM: pe_en drops immediately (asynchronous). The partial burst is abandoned, and the array resets with the same rst.
- s_last on the beat that fills the buffer to exactly MAX_LEN: seq_len=MAX_LEN, ovf=0.
- Beats beyond MAX_LEN: the s_last beat itself is discarded if it is past MAX_LEN. seq_len=MAX_LEN and ovf=1.

## Structure
- Shared package sw_pkg, also used by the PE array:
  - Nucleotide encodings _A/_G/_T/_C.
  - Default SCORE_WIDTH.
  - ZERO bias expression.
  - Feeder state encoding (one-hot, 4 bits).
- One sub-module, sw_target_buf:
  - Simple dual-port RAM, MAX_LEN×2 bits.
  - One write port, one synchronous read port.
  - No reset.
- The FSM, counters and output registers live in sw_target_feeder.

## Test plan
- Load sequence A,G,T,C (s_last on C), hold res_vld=0 → pe_en high for exactly 4 consecutive cycles starting 2 cycles after s_last; pe_data=00,01,10,11; s_ready=0, busy=1 until res_vld.
- Single base T with s_last → one-cycle pe_en burst with pe_data=10, seq_len=1.
- MAX_LEN+3 beats, last on the final beat → only MAX_LEN cycles of pe_en; ovf=1; seq_len=MAX_LEN; ovf clears after res_vld.
- Random s_valid stalls (50%) while loading 8 bases → pe_en burst is still 8 contiguous cycles in the loaded order.
- rst pulsed during the 3rd STREAM cycle → pe_en=0 and s_ready=1 immediately; the next sequence of 2 bases streams correctly.
- res_vld pulsed in LOAD and STREAM → no effect. Pulsed in WAIT_RES → s_ready=1 next cycle. pe_M, pe_I and pe_High read 0x800 throughout (SCORE_WIDTH=12).
